// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Purpose  : Instruction fetch controller. It owns the program counter and
//            fetches an opcode byte plus 0-2 operand bytes over a req/ack
//            memory port. It then presents the opcode and operand to the
//            decoder and holds them until the decoder reports completion.
//            PC loads for jumps and branches are accepted together with
//            instruction_done.
// Ports    : clk, reset           - clock, asynchronous active-high reset
//            mem_addr/mem_req     - fetch address and request (held to ack)
//            mem_ack/mem_rdata    - memory byte handshake
//            instruction_out      - latched opcode
//            addr_out             - latched operand {hi,lo}
//            operand_len          - operand bytes fetched (0/1/2)
//            instruction_ready    - opcode/operand valid for the decoder
//            instruction_done     - decoder finished the current instruction
//            pc_load/_value       - replace the next PC (with done only)
//            halt                 - stop before the next opcode fetch
//            pc                   - current program counter
//            busy                 - low only while halted
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    REG_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0600
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [REG_WIDTH-1:0]  instruction_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            operand_len,
  output logic                  instruction_ready,
  input  logic                  instruction_done,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_load_value,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  busy
);

  // The operand is assembled as {hi,lo}, so the address is two data bytes.
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    FETCH_OP = 3'd0,
    FETCH_LO = 3'd1,
    FETCH_HI = 3'd2,
    ISSUE    = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_WIDTH-1:0]   pc_next;
  logic [ADDR_WIDTH-1:0]   mem_addr_next;
  logic                    mem_req_next;
  logic [REG_WIDTH-1:0]    instr_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [1:0]              len_next;
  logic                    ready_next;
  logic                    busy_next;

  // Operand byte count decoded from the opcode; earlier rules take priority.
  function automatic logic [1:0] op_len(input logic [REG_WIDTH-1:0] op);
    logic [2:0] b;
    logic [1:0] c;
    b = op[4:2];
    c = op[1:0];
    if (op == REG_WIDTH'(8'h20)) begin
      op_len = 2'd2;
    end else if (op == REG_WIDTH'(8'h00) || op == REG_WIDTH'(8'h40) ||
                 op == REG_WIDTH'(8'h60)) begin
      op_len = 2'd0;
    end else if (b == 3'b011 || b == 3'b111) begin
      op_len = 2'd2;
    end else if (b == 3'b110) begin
      op_len = (c == 2'b01) ? 2'd2 : 2'd0;
    end else if (b == 3'b010) begin
      op_len = (c == 2'b01) ? 2'd1 : 2'd0;
    end else begin
      op_len = 2'd1;
    end
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= FETCH_OP;
      pc                <= RESET_PC;
      mem_req           <= 1'b0;
      mem_addr          <= '0;
      instruction_out   <= '0;
      addr_out          <= '0;
      operand_len       <= 2'd0;
      instruction_ready <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_next;
      pc                <= pc_next;
      mem_req           <= mem_req_next;
      mem_addr          <= mem_addr_next;
      instruction_out   <= instr_next;
      addr_out          <= addr_next;
      operand_len       <= len_next;
      instruction_ready <= ready_next;
      busy              <= busy_next;
    end
  end

  // All outputs are registered: the comb block computes next values only.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    mem_req_next  = mem_req;
    mem_addr_next = mem_addr;
    instr_next    = instruction_out;
    addr_next     = addr_out;
    len_next      = operand_len;
    ready_next    = instruction_ready;

    case (state)
      FETCH_OP: begin
        if (!mem_req) begin
          // Entry cycle: this is the only place halt is honoured, and any
          // ack arriving here (e.g. straight after reset) is ignored.
          if (halt) begin
            state_next = HALTED;
          end else begin
            mem_req_next  = 1'b1;
            mem_addr_next = pc;
          end
        end else if (mem_ack) begin
          instr_next = mem_rdata;
          addr_next  = '0;
          len_next   = op_len(mem_rdata);
          pc_next    = pc + PC_ONE;
          if (op_len(mem_rdata) == 2'd0) begin
            state_next   = ISSUE;
            mem_req_next = 1'b0;
            ready_next   = 1'b1;
          end else begin
            // Keep the request up so the operand fetch costs no idle cycle.
            state_next    = FETCH_LO;
            mem_addr_next = pc + PC_ONE;
          end
        end
      end

      FETCH_LO: begin
        if (mem_req && mem_ack) begin
          addr_next[REG_WIDTH-1:0] = mem_rdata;
          pc_next = pc + PC_ONE;
          if (operand_len == 2'd2) begin
            state_next    = FETCH_HI;
            mem_addr_next = pc + PC_ONE;
          end else begin
            state_next   = ISSUE;
            mem_req_next = 1'b0;
            ready_next   = 1'b1;
          end
        end
      end

      FETCH_HI: begin
        if (mem_req && mem_ack) begin
          addr_next[REG_WIDTH +: REG_WIDTH] = mem_rdata;
          pc_next      = pc + PC_ONE;
          state_next   = ISSUE;
          mem_req_next = 1'b0;
          ready_next   = 1'b1;
        end
      end

      ISSUE: begin
        if (instruction_done) begin
          ready_next = 1'b0;
          state_next = FETCH_OP;
          if (pc_load) begin
            pc_next = pc_load_value;
          end
        end
      end

      HALTED: begin
        if (!halt) begin
          state_next = FETCH_OP;
        end
      end

      default: begin
        state_next   = FETCH_OP;
        mem_req_next = 1'b0;
        ready_next   = 1'b0;
      end
    endcase

    busy_next = (state_next != HALTED);
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module   : tb_fetch_sequencer
// Purpose  : Self-checking bench for fetch_sequencer. A program-level model
//            (opcode address plus bytes fetched so far) predicts every fetch
//            address and every issued instruction. Directed literal checks
//            pin the model against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (RESET_PC = 0600)
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  instruction_out;
  logic [15:0] addr_out;
  logic [1:0]  operand_len;
  logic        instruction_ready;
  logic        instruction_done = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_load_value = 16'h0000;
  logic        halt = 1'b0;
  logic [15:0] pc;
  logic        busy;

  fetch_sequencer #(.ADDR_WIDTH(16), .REG_WIDTH(8), .RESET_PC(16'h0600)) dut (
    .clk(clk), .reset(reset),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instruction_out(instruction_out), .addr_out(addr_out), .operand_len(operand_len),
    .instruction_ready(instruction_ready), .instruction_done(instruction_done),
    .pc_load(pc_load), .pc_load_value(pc_load_value), .halt(halt),
    .pc(pc), .busy(busy)
  );

  // Wrap-around DUT (RESET_PC = FFFF)
  logic [15:0] w2_addr;
  logic        w2_req;
  logic        w2_ack = 1'b0;
  logic [7:0]  w2_rdata = 8'h00;
  logic [7:0]  w2_instr;
  logic [15:0] w2_operand;
  logic [1:0]  w2_len;
  logic        w2_ready;
  logic        w2_done = 1'b0;
  logic        w2_load = 1'b0;
  logic [15:0] w2_load_value = 16'h0000;
  logic        w2_halt = 1'b0;
  logic [15:0] w2_pc;
  logic        w2_busy;

  fetch_sequencer #(.ADDR_WIDTH(16), .REG_WIDTH(8), .RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(reset),
    .mem_addr(w2_addr), .mem_req(w2_req), .mem_ack(w2_ack), .mem_rdata(w2_rdata),
    .instruction_out(w2_instr), .addr_out(w2_operand), .operand_len(w2_len),
    .instruction_ready(w2_ready), .instruction_done(w2_done),
    .pc_load(w2_load), .pc_load_value(w2_load_value), .halt(w2_halt),
    .pc(w2_pc), .busy(w2_busy)
  );

  // --------------------------------------------------------------------------
  // Bookkeeping
  // --------------------------------------------------------------------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Operand count of an opcode, straight from the decode rules.
  function automatic int mlen(input logic [7:0] op);
    logic [2:0] b;
    logic [1:0] c;
    b = op[4:2];
    c = op[1:0];
    if (op == 8'h20) return 2;
    if (op == 8'h00 || op == 8'h40 || op == 8'h60) return 0;
    case (b)
      3'b011, 3'b111: return 2;
      3'b110:         return (c == 2'b01) ? 2 : 0;
      3'b010:         return (c == 2'b01) ? 1 : 0;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [7:0] wrap_mem(input logic [15:0] a);
    case (a)
      16'hFFFF: return 8'h4C;
      16'h0000: return 8'h34;
      16'h0001: return 8'h12;
      default:  return 8'hEA;
    endcase
  endfunction

  logic [7:0] mem [0:65535];

  // --------------------------------------------------------------------------
  // Memory responders
  // --------------------------------------------------------------------------
  int ack_delay = 0;
  bit resp_en   = 1'b1;
  bit force_ack = 1'b0;
  bit chk_en    = 1'b0;

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'hFF;
      end else if (resp_en && mem_req && !reset) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = mem[mem_addr];
          wait_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt = wait_cnt + 1;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      w2_ack   = w2_req && !reset;
      w2_rdata = wrap_mem(w2_addr);
    end
  end

  // --------------------------------------------------------------------------
  // Program-level model: address of the current opcode and bytes taken so far
  // --------------------------------------------------------------------------
  logic [15:0] m_pc;
  int          m_k;
  logic [15:0] ack_log [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= 16'h0600;
      m_k  <= 0;
    end else begin
      if (mem_req && mem_ack) begin
        m_k <= m_k + 1;
        ack_log.push_back(mem_addr);
      end
      if (instruction_ready && instruction_done) begin
        m_pc <= pc_load ? pc_load_value : m_pc + 16'(1 + mlen(mem[m_pc]));
        m_k  <= 0;
      end
    end
  end

  // Compare process: fetch address while requesting, full instruction when ready.
  initial begin
    logic [7:0]  e_op;
    logic [15:0] e_a1;
    logic [15:0] e_a2;
    logic [15:0] e_addr;
    int          e_len;
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        if (mem_req) begin
          check("model_mem_addr", 32'(mem_addr), 32'(m_pc + 16'(m_k)));
        end
        if (instruction_ready) begin
          e_op  = mem[m_pc];
          e_len = mlen(e_op);
          e_a1  = m_pc + 16'd1;
          e_a2  = m_pc + 16'd2;
          e_addr = 16'h0000;
          if (e_len >= 1) e_addr[7:0]  = mem[e_a1];
          if (e_len == 2) e_addr[15:8] = mem[e_a2];
          check("model_req_in_issue", 32'(mem_req), 32'd0);
          check("model_opcode", 32'(instruction_out), 32'(e_op));
          check("model_operand", 32'(addr_out), 32'(e_addr));
          check("model_len", 32'(operand_len), 32'(e_len));
          check("model_pc", 32'(pc), 32'(m_pc + 16'(1 + e_len)));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed sequence helpers (all entered and left on a falling edge)
  // --------------------------------------------------------------------------
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!instruction_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(instruction_ready), 32'd1);
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (!mem_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic done_pulse(input logic ld, input logic [15:0] v);
    pc_load          = ld;
    pc_load_value    = v;
    instruction_done = 1'b1;
    @(negedge clk);
    instruction_done = 1'b0;
    pc_load          = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int nlog;
    int n;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'h0600] = 8'hA9; mem[16'h0601] = 8'h42;
    mem[16'h0602] = 8'h8D; mem[16'h0603] = 8'h00; mem[16'h0604] = 8'h02;
    mem[16'h0605] = 8'h0A;
    mem[16'h0700] = 8'hA9; mem[16'h0701] = 8'h55;
    mem[16'h0702] = 8'hA9; mem[16'h0703] = 8'h77;

    // Reset values
    #2 reset = 1'b1;
    #1;
    check("rst_pc", 32'(pc), 32'h0600);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_instr", 32'(instruction_out), 32'h0);
    check("rst_addr_out", 32'(addr_out), 32'h0);
    check("rst_len", 32'(operand_len), 32'd0);
    check("rst_ready", 32'(instruction_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // LDA #$42 with immediate acks
    wait_ready("t1_ready");
    check("t1_opcode", 32'(instruction_out), 32'hA9);
    check("t1_operand", 32'(addr_out), 32'h0042);
    check("t1_len", 32'(operand_len), 32'd1);
    check("t1_pc", 32'(pc), 32'h0602);
    check("t1_fetch0", 32'(ack_log[0]), 32'h0600);
    check("t1_fetch1", 32'(ack_log[1]), 32'h0601);

    // Wrap-around instance: JMP $1234 from FFFF
    n = 0;
    while (!w2_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wrap_ready", 32'(w2_ready), 32'd1);
    check("wrap_opcode", 32'(w2_instr), 32'h4C);
    check("wrap_operand", 32'(w2_operand), 32'h1234);
    check("wrap_len", 32'(w2_len), 32'd2);
    check("wrap_pc", 32'(w2_pc), 32'h0002);
    check("wrap_busy", 32'(w2_busy), 32'd1);

    // Hold in ISSUE; pc_load without done is ignored
    repeat (2) @(negedge clk);
    pc_load       = 1'b1;
    pc_load_value = 16'h1234;
    repeat (2) @(negedge clk);
    pc_load = 1'b0;
    check("ldnodone_pc", 32'(pc), 32'h0602);
    check("ldnodone_ready", 32'(instruction_ready), 32'd1);

    // STA $0200 with a three-cycle memory delay
    ack_delay = 3;
    done_pulse(1'b0, 16'h0000);
    wait_ready("t2_ready");
    check("t2_opcode", 32'(instruction_out), 32'h8D);
    check("t2_operand", 32'(addr_out), 32'h0200);
    check("t2_len", 32'(operand_len), 32'd2);
    check("t2_pc", 32'(pc), 32'h0605);

    // ASL A: a single fetch
    ack_delay = 0;
    nlog = ack_log.size();
    done_pulse(1'b0, 16'h0000);
    wait_ready("t3_ready");
    check("t3_opcode", 32'(instruction_out), 32'h0A);
    check("t3_operand", 32'(addr_out), 32'h0000);
    check("t3_len", 32'(operand_len), 32'd0);
    check("t3_pc", 32'(pc), 32'h0606);
    check("t3_fetches", 32'(ack_log.size() - nlog), 32'd1);

    // Jump via pc_load with done
    done_pulse(1'b1, 16'h0700);
    wait_req("t4_req");
    check("t4_jump_addr", 32'(mem_addr), 32'h0700);
    wait_ready("t4_ready");
    check("t4_operand", 32'(addr_out), 32'h0055);
    check("t4_pc", 32'(pc), 32'h0702);

    // halt raised during the operand fetch
    ack_delay = 3;
    done_pulse(1'b0, 16'h0000);
    n = 0;
    while (!(mem_req && m_k == 1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_fetch_lo", 32'(m_k), 32'd1);
    halt = 1'b1;
    wait_ready("t5_ready");
    check("t5_opcode", 32'(instruction_out), 32'hA9);
    check("t5_operand", 32'(addr_out), 32'h0077);
    done_pulse(1'b0, 16'h0000);
    repeat (4) @(negedge clk);
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_req", 32'(mem_req), 32'd0);
    check("halt_pc", 32'(pc), 32'h0704);
    halt = 1'b0;
    wait_req("unhalt_req");
    check("unhalt_addr", 32'(mem_addr), 32'h0704);
    check("unhalt_busy", 32'(busy), 32'd1);

    // Reset while waiting for an ack; a late ack must be ignored
    resp_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_req", 32'(mem_req), 32'd0);
    check("midrst_pc", 32'(pc), 32'h0600);
    check("midrst_busy", 32'(busy), 32'd0);
    force_ack = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    force_ack = 1'b0;
    resp_en   = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    wait_ready("postrst_ready");
    check("postrst_opcode", 32'(instruction_out), 32'hA9);
    check("postrst_pc", 32'(pc), 32'h0602);

    // Reset while an instruction is being presented
    #2 reset = 1'b1;
    #1;
    check("issuerst_ready", 32'(instruction_ready), 32'd0);
    check("issuerst_opcode", 32'(instruction_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch controller that sequences the decoder. It owns the program counter and reads the opcode byte and 0–2 operand bytes from memory over a req/ack handshake. It then presents the opcode and operand to the decoder with instruction_ready and holds them until the decoder returns instruction_done. It sits between the memory port and the decoder, and also accepts PC loads for jumps and branches.

Parameters:
ADDR_WIDTH, 16, program counter and memory address width
REG_WIDTH, 8, opcode and data byte width
RESET_PC, 16'h0600, PC value loaded on reset

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
mem_addr  output  ADDR_WIDTH  byte address of the current fetch
mem_req  output  1  fetch request; held until mem_ack
mem_ack  input  1  memory has placed a valid byte on mem_rdata this cycle
mem_rdata  input  REG_WIDTH  fetched byte
instruction_out  output  REG_WIDTH  latched opcode
addr_out  output  ADDR_WIDTH  latched operand, {hi,lo}; hi=0 for 1-byte operands, all 0 for none
operand_len  output  2  number of operand bytes fetched (0/1/2)
instruction_ready  output  1  opcode/operand valid, decoder may execute
instruction_done  input  1  decoder finished current instruction
pc_load  input  1  with instruction_done, replaces next PC
pc_load_value  input  ADDR_WIDTH  target PC for pc_load
halt  input  1  stop before the next opcode fetch
pc  output  ADDR_WIDTH  current program counter
busy  output  1  high in every state except HALTED

Behaviour:
- Reset (async, immediate) values: pc=RESET_PC, mem_req=0, mem_addr=0, instruction_out=0, addr_out=0, operand_len=0, instruction_ready=0, busy=0, state=FETCH_OP. An in-flight request is abandoned, and any late mem_ack is ignored.
- States: FETCH_OP, FETCH_LO, FETCH_HI, ISSUE, HALTED.
- In the fetch states, mem_req=1 and mem_addr=pc. On the cycle mem_ack=1, the byte is captured and pc increments by 1 (wrapping FFFF->0000). mem_addr stays stable while waiting. mem_ack seen while mem_req=0 is ignored.
- FETCH_OP:
  - If halt=1 on entry, go to HALTED with no request.
  - On ack: latch instruction_out, clear addr_out, compute len from the captured byte, and set operand_len.
  - Next state: len=0 -> ISSUE; else -> FETCH_LO.
- Length rule, with b=op[4:2] and c=op[1:0], applied in priority order:
  1. op=8'h20 -> 2.
  2. op in {00,40,60} -> 0.
  3. b in {011,111} -> 2.
  4. b=110: c=01 -> 2, else 0.
  5. b=010: c=01 -> 1, else 0.
  6. Otherwise -> 1.
- FETCH_LO: on ack, addr_out[7:0]=byte. len=1 -> ISSUE; len=2 -> FETCH_HI.
- FETCH_HI: on ack, addr_out[15:8]=byte, then -> ISSUE.
- ISSUE:
  - instruction_ready=1 and mem_req=0. Outputs are held constant while instruction_ready is high.
  - On instruction_done=1, instruction_ready drops the next cycle and the state returns to FETCH_OP.
  - If pc_load=1 in the same cycle, pc becomes pc_load_value; otherwise pc keeps its value (already past the operands).
  - pc_load without instruction_done is ignored.
  - instruction_done outside ISSUE is ignored.
- Minimum latency: opcode ack at cycle N gives instruction_ready at N+1 for len=0. Each operand byte adds one request cycle plus the memory wait.
- HALTED: busy=0, no requests, pc frozen. When halt drops, go to FETCH_OP on the next cycle. halt asserted mid-instruction takes effect only at the next FETCH_OP.
- Reset during any state, including ISSUE with instruction_ready high, returns to the reset values within the same cycle (asynchronous).

Test Plan:
- Reset release, memory 0600:A9 0601:42, ack on the first request cycle -> mem_addr 0600 then 0601; instruction_out=A9, addr_out=0042, operand_len=1, instruction_ready high, pc=0602.
- 0602:8D 0603:00 0604:02 with 3-cycle ack delay -> mem_addr holds each value while waiting; addr_out=0200, operand_len=2, pc=0605.
- 0605:0A (ASL A) -> operand_len=0, addr_out=0000, only one fetch, pc=0606; instruction_done -> next fetch from 0606.
- instruction_done with pc_load=1, pc_load_value=0700 -> next mem_addr=0700. pc_load=1 without done -> ignored, pc unchanged.
- RESET_PC=FFFF, FFFF:4C 0000:34 0001:12 -> pc wraps to 0000, addr_out=1234, final pc=0002.
- halt raised during FETCH_LO -> instruction completes, then HALTED with busy=0 and no mem_req. Reset pulsed while waiting for ack -> mem_req=0 immediately; late ack ignored; pc=RESET_PC.
